// File: rtl/pwm_ramp_ctrl_if.sv
// Target-duty command handshake between a sequencer master and pwm_ramp_ctrl.
interface pwm_ramp_ctrl_if;
    logic       cmd_vld;
    logic [9:0] cmd_duty;
    logic       cmd_rdy;

    modport master (output cmd_vld, output cmd_duty, input cmd_rdy);
    modport slave  (input cmd_vld, input cmd_duty, output cmd_rdy);
endinterface

// File: rtl/pwm_ramp_ctrl.sv
// Slews the 10-bit PWM duty toward commanded targets once per PWM period.
// Optional PWM_FAULT_EN adds a sticky fault shutdown and the fault_lat port.
module pwm_ramp_ctrl #(
    parameter int unsigned STEP     = 16,
    parameter logic [9:0]  MAX_DUTY = 10'h3F0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pwm_ramp_ctrl_if.slave       cmd,
    input  logic                 stop_req,
    input  logic                 fault,
    output logic [9:0]           duty,
    output logic                 period_end,
    output logic                 at_target,
    output logic                 busy
`ifdef PWM_FAULT_EN
    ,
    output logic                 fault_lat
`endif
);

    typedef enum logic [1:0] {IDLE, RAMP, HOLD, STOP} state_t;

    localparam logic [10:0] STEP11 = 11'(STEP);
    localparam logic [9:0]  STEP10 = 10'(STEP);

    state_t      state, state_nx;
    logic [9:0]  cnt;
    logic [9:0]  target, target_nx;
    logic [9:0]  duty_nx;
    logic [9:0]  step_res;
    logic [9:0]  clamp;
    logic [10:0] diff;
    logic        accept;
    logic        fault_hit;
    logic        blocked;

`ifdef PWM_FAULT_EN
    logic fault_lat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            fault_lat_q <= 1'b0;
        else if (fault)
            fault_lat_q <= 1'b1;
    end

    assign fault_lat = fault_lat_q;
    assign fault_hit = fault;
    assign blocked   = fault_lat_q | fault;
`else
    logic fault_unused;
    assign fault_unused = fault;
    assign fault_hit    = 1'b0;
    assign blocked      = 1'b0;
`endif

    // Same reset as the PWM counter, so cnt tracks it cycle for cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else
            cnt <= cnt + 10'd1;
    end

    assign period_end  = (cnt == 10'h3FF);
    assign clamp       = (cmd.cmd_duty > MAX_DUTY) ? MAX_DUTY : cmd.cmd_duty;
    assign cmd.cmd_rdy = (state != STOP) && !stop_req && !blocked;
    assign accept      = cmd.cmd_vld && cmd.cmd_rdy;

    always_comb begin
        diff     = '0;
        step_res = target;
        if (target > duty)
            diff = {1'b0, target} - {1'b0, duty};
        else
            diff = {1'b0, duty} - {1'b0, target};
        if (diff <= STEP11)
            step_res = target;
        else if (target > duty)
            step_res = duty + STEP10;
        else
            step_res = duty - STEP10;
    end

    // Stepping uses the target held before this edge, so a command landing on
    // the period_end edge only shows up at the following boundary.
    always_comb begin
        state_nx  = state;
        target_nx = target;
        duty_nx   = duty;
        if (period_end && (state == RAMP || state == STOP))
            duty_nx = step_res;
        case (state)
            IDLE: begin
                if (accept && clamp != '0) begin
                    target_nx = clamp;
                    state_nx  = RAMP;
                end
            end
            RAMP, HOLD: begin
                if (state == RAMP && period_end && step_res == target)
                    state_nx = HOLD;
                if (stop_req) begin
                    state_nx  = STOP;
                    target_nx = '0;
                end else if (accept) begin
                    target_nx = clamp;
                    if (clamp != duty_nx)
                        state_nx = RAMP;
                end
            end
            STOP: begin
                if (period_end && step_res == '0)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (fault_hit) begin
            state_nx  = IDLE;
            target_nx = '0;
            duty_nx   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            target    <= '0;
            duty      <= '0;
            at_target <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nx;
            target    <= target_nx;
            duty      <= duty_nx;
            at_target <= (state_nx == HOLD) && (duty_nx == target_nx);
            busy      <= (state_nx == RAMP) || (state_nx == STOP);
        end
    end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Self-checking bench for pwm_ramp_ctrl: directed scenarios plus a randomized
// run against a period-level reference model. Honours PWM_FAULT_EN.
module tb_pwm_ramp_ctrl;

    logic       clk;
    logic       rst_n;
    logic       stop_a, stop_b;
    logic       fault_a, fault_b;
    logic [9:0] duty_a, duty_b;
    logic       pe_a, pe_b;
    logic       at_a, at_b;
    logic       busy_a, busy_b;
`ifdef PWM_FAULT_EN
    logic       flat_a, flat_b;
`endif
    logic [9:0] tb_cnt;
    int         n_checks;
    int         n_fail;

    pwm_ramp_ctrl_if ci ();
    pwm_ramp_ctrl_if ci2 ();

    pwm_ramp_ctrl u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd        (ci),
        .stop_req   (stop_a),
        .fault      (fault_a),
        .duty       (duty_a),
        .period_end (pe_a),
        .at_target  (at_a),
        .busy       (busy_a)
`ifdef PWM_FAULT_EN
        ,
        .fault_lat  (flat_a)
`endif
    );

    // Single-step instance: reaches any target in one period.
    pwm_ramp_ctrl #(.STEP(1023)) u_big (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd        (ci2),
        .stop_req   (stop_b),
        .fault      (fault_b),
        .duty       (duty_b),
        .period_end (pe_b),
        .at_target  (at_b),
        .busy       (busy_b)
`ifdef PWM_FAULT_EN
        ,
        .fault_lat  (flat_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_cnt <= '0;
        else        tb_cnt <= tb_cnt + 10'd1;
    end

    task automatic wait_cnt(input int unsigned v);
        int unsigned k;
        k = 0;
        @(negedge clk);
        while (tb_cnt != 10'(v) && k < 2100) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        n_checks++; if (duty_a !== 10'd0) begin n_fail++; $display("FAIL reset_duty got %0d want 0", duty_a); end
        n_checks++; if (at_a !== 1'b0) begin n_fail++; $display("FAIL reset_at_target got %b want 0", at_a); end
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy_a); end
        n_checks++; if (pe_a !== 1'b0) begin n_fail++; $display("FAIL reset_period_end got %b want 0", pe_a); end
        n_checks++; if (ci.cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_rdy got %b want 1", ci.cmd_rdy); end
        n_checks++; if (duty_b !== 10'd0) begin n_fail++; $display("FAIL reset_big_duty got %0d want 0", duty_b); end
`ifdef PWM_FAULT_EN
        n_checks++; if (flat_a !== 1'b0) begin n_fail++; $display("FAIL reset_fault_lat got %b want 0", flat_a); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_ramp_up();
        int exp_seq [7] = '{16, 32, 48, 64, 80, 96, 100};
        int prev;
        prev = 0;
        wait_cnt(5);
        ci.cmd_vld = 1'b1; ci.cmd_duty = 10'd100;
        #1;
        n_checks++; if (ci.cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL ramp_cmd_rdy got %b want 1", ci.cmd_rdy); end
        @(negedge clk);
        ci.cmd_vld = 1'b0;
        n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL ramp_busy_start got %b want 1", busy_a); end
        for (int i = 0; i < 7; i++) begin
            wait_cnt(512);
            n_checks++; if (duty_a !== 10'(prev)) begin n_fail++; $display("FAIL ramp_mid_hold[%0d] got %0d want %0d", i, duty_a, prev); end
            wait_cnt(1023);
            n_checks++; if (pe_a !== 1'b1) begin n_fail++; $display("FAIL ramp_period_end[%0d] got %b want 1", i, pe_a); end
            n_checks++; if (duty_a !== 10'(prev)) begin n_fail++; $display("FAIL ramp_pre_edge[%0d] got %0d want %0d", i, duty_a, prev); end
            @(negedge clk);
            n_checks++; if (duty_a !== 10'(exp_seq[i])) begin n_fail++; $display("FAIL ramp_duty[%0d] got %0d want %0d", i, duty_a, exp_seq[i]); end
            prev = exp_seq[i];
        end
        n_checks++; if (at_a !== 1'b1) begin n_fail++; $display("FAIL ramp_at_target got %b want 1", at_a); end
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL ramp_busy_end got %b want 0", busy_a); end
    endtask

    task automatic test_stop_vs_cmd();
        int e;
        wait_cnt(300);
        stop_a = 1'b1; ci.cmd_vld = 1'b1; ci.cmd_duty = 10'd500;
        #1;
        n_checks++; if (ci.cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL stop_cmd_rdy got %b want 0", ci.cmd_rdy); end
        @(negedge clk);
        stop_a = 1'b0; ci.cmd_vld = 1'b0;
        n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL stop_busy got %b want 1", busy_a); end
        n_checks++; if (ci.cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL stop_rdy_in_stop got %b want 0", ci.cmd_rdy); end
        for (int k = 1; k <= 7; k++) begin
            e = 100 - 16 * k;
            if (e < 0) e = 0;
            wait_cnt(1023);
            @(negedge clk);
            n_checks++; if (duty_a !== 10'(e)) begin n_fail++; $display("FAIL stop_duty[%0d] got %0d want %0d", k, duty_a, e); end
        end
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL stop_idle_busy got %b want 0", busy_a); end
        n_checks++; if (at_a !== 1'b0) begin n_fail++; $display("FAIL stop_idle_at_target got %b want 0", at_a); end
        n_checks++; if (ci.cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL stop_idle_rdy got %b want 1", ci.cmd_rdy); end
    endtask

    task automatic test_retarget();
        int exp_seq [5] = '{16, 32, 48, 32, 20};
        wait_cnt(10);
        ci.cmd_vld = 1'b1; ci.cmd_duty = 10'd100;
        @(negedge clk);
        ci.cmd_vld = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) begin
                wait_cnt(100);
                ci.cmd_vld = 1'b1; ci.cmd_duty = 10'd20;
                @(negedge clk);
                ci.cmd_vld = 1'b0;
            end
            wait_cnt(1023);
            @(negedge clk);
            n_checks++; if (duty_a !== 10'(exp_seq[i])) begin n_fail++; $display("FAIL retarget_duty[%0d] got %0d want %0d", i, duty_a, exp_seq[i]); end
        end
        n_checks++; if (at_a !== 1'b1) begin n_fail++; $display("FAIL retarget_at_target got %b want 1", at_a); end
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL retarget_busy got %b want 0", busy_a); end
    endtask

    task automatic test_boundary();
        wait_cnt(1022);
        ci.cmd_vld = 1'b1; ci.cmd_duty = 10'd40;
        @(negedge clk);
        ci.cmd_vld = 1'b0;
        n_checks++; if (duty_a !== 10'd20) begin n_fail++; $display("FAIL bnd_3fe_pre got %0d want 20", duty_a); end
        @(negedge clk);
        n_checks++; if (duty_a !== 10'd36) begin n_fail++; $display("FAIL bnd_3fe_step got %0d want 36", duty_a); end
        wait_cnt(1023);
        @(negedge clk);
        n_checks++; if (duty_a !== 10'd40) begin n_fail++; $display("FAIL bnd_3fe_final got %0d want 40", duty_a); end
        wait_cnt(1023);
        ci.cmd_vld = 1'b1; ci.cmd_duty = 10'd60;
        #1;
        n_checks++; if (ci.cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL bnd_3ff_rdy got %b want 1", ci.cmd_rdy); end
        @(negedge clk);
        ci.cmd_vld = 1'b0;
        n_checks++; if (duty_a !== 10'd40) begin n_fail++; $display("FAIL bnd_3ff_no_step got %0d want 40", duty_a); end
        n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL bnd_3ff_busy got %b want 1", busy_a); end
        wait_cnt(512);
        n_checks++; if (duty_a !== 10'd40) begin n_fail++; $display("FAIL bnd_3ff_mid got %0d want 40", duty_a); end
        wait_cnt(1023);
        @(negedge clk);
        n_checks++; if (duty_a !== 10'd56) begin n_fail++; $display("FAIL bnd_3ff_step got %0d want 56", duty_a); end
        wait_cnt(1023);
        @(negedge clk);
        n_checks++; if (duty_a !== 10'd60) begin n_fail++; $display("FAIL bnd_3ff_final got %0d want 60", duty_a); end
        n_checks++; if (at_a !== 1'b1) begin n_fail++; $display("FAIL bnd_at_target got %b want 1", at_a); end
    endtask

    task automatic test_reset_mid_ramp();
        pulse_reset();
        wait_cnt(10);
        ci.cmd_vld = 1'b1; ci.cmd_duty = 10'd100;
        @(negedge clk);
        ci.cmd_vld = 1'b0;
        repeat (4) begin
            wait_cnt(1023);
            @(negedge clk);
        end
        wait_cnt(400);
        n_checks++; if (duty_a !== 10'd64) begin n_fail++; $display("FAIL rst_mid_pre_duty got %0d want 64", duty_a); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (duty_a !== 10'd0) begin n_fail++; $display("FAIL rst_mid_duty got %0d want 0", duty_a); end
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy got %b want 0", busy_a); end
        n_checks++; if (ci.cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL rst_mid_rdy got %b want 1", ci.cmd_rdy); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_clamp();
        wait_cnt(50);
        ci2.cmd_vld = 1'b1; ci2.cmd_duty = 10'h3FF;
        @(negedge clk);
        ci2.cmd_vld = 1'b0;
        n_checks++; if (busy_b !== 1'b1) begin n_fail++; $display("FAIL clamp_busy got %b want 1", busy_b); end
        wait_cnt(1023);
        n_checks++; if (duty_b !== 10'd0) begin n_fail++; $display("FAIL clamp_pre got %0d want 0", duty_b); end
        @(negedge clk);
        n_checks++; if (duty_b !== 10'h3F0) begin n_fail++; $display("FAIL clamp_duty got %h want 3f0", duty_b); end
        n_checks++; if (at_b !== 1'b1) begin n_fail++; $display("FAIL clamp_at_target got %b want 1", at_b); end
        wait_cnt(100);
        ci2.cmd_vld = 1'b1; ci2.cmd_duty = 10'h3FF;
        @(negedge clk);
        ci2.cmd_vld = 1'b0;
        n_checks++; if (busy_b !== 1'b0) begin n_fail++; $display("FAIL clamp_same_busy got %b want 0", busy_b); end
        wait_cnt(1023);
        @(negedge clk);
        n_checks++; if (duty_b !== 10'h3F0) begin n_fail++; $display("FAIL clamp_hold got %h want 3f0", duty_b); end
    endtask

    task automatic test_fault();
        wait_cnt(150);
        ci2.cmd_vld = 1'b1; ci2.cmd_duty = 10'd300;
        @(negedge clk);
        ci2.cmd_vld = 1'b0;
        wait_cnt(1023);
        @(negedge clk);
        n_checks++; if (duty_b !== 10'd300) begin n_fail++; $display("FAIL fault_pre_duty got %0d want 300", duty_b); end
        wait_cnt(200);
        fault_b = 1'b1;
        @(negedge clk);
        fault_b = 1'b0;
`ifdef PWM_FAULT_EN
        n_checks++; if (duty_b !== 10'd0) begin n_fail++; $display("FAIL fault_duty got %0d want 0", duty_b); end
        n_checks++; if (flat_b !== 1'b1) begin n_fail++; $display("FAIL fault_lat got %b want 1", flat_b); end
        n_checks++; if (ci2.cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL fault_rdy got %b want 0", ci2.cmd_rdy); end
        n_checks++; if (busy_b !== 1'b0) begin n_fail++; $display("FAIL fault_busy got %b want 0", busy_b); end
        ci2.cmd_vld = 1'b1; ci2.cmd_duty = 10'd500;
        @(negedge clk);
        ci2.cmd_vld = 1'b0;
        wait_cnt(1023);
        @(negedge clk);
        n_checks++; if (duty_b !== 10'd0) begin n_fail++; $display("FAIL fault_stays_off got %0d want 0", duty_b); end
        n_checks++; if (ci2.cmd_rdy !== 1'b0) begin n_fail++; $display("FAIL fault_rdy_sticky got %b want 0", ci2.cmd_rdy); end
        pulse_reset();
        n_checks++; if (flat_b !== 1'b0) begin n_fail++; $display("FAIL fault_lat_clear got %b want 0", flat_b); end
        n_checks++; if (ci2.cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL fault_rdy_clear got %b want 1", ci2.cmd_rdy); end
`else
        n_checks++; if (duty_b !== 10'd300) begin n_fail++; $display("FAIL fault_ignored_duty got %0d want 300", duty_b); end
        n_checks++; if (ci2.cmd_rdy !== 1'b1) begin n_fail++; $display("FAIL fault_ignored_rdy got %b want 1", ci2.cmd_rdy); end
        n_checks++; if (at_b !== 1'b1) begin n_fail++; $display("FAIL fault_ignored_at got %b want 1", at_b); end
        pulse_reset();
`endif
    endtask

    // Model works in terms of the spec's rules: latest target, duty moved by at
    // most STEP per boundary, plus idle / holding / stopping flags.
    task automatic test_random();
        int  m_duty, m_target, c, d;
        bit  m_idle, m_hold, m_stop, pe, acc, exp_rdy;
        pulse_reset();
        m_duty = 0; m_target = 0; m_idle = 1; m_hold = 0; m_stop = 0;
        for (int unsigned cyc = 0; cyc < 16 * 1024; cyc++) begin
            n_checks++; if (duty_a !== 10'(m_duty)) begin n_fail++; $display("FAIL rnd_duty cyc %0d got %0d want %0d", cyc, duty_a, m_duty); end
            n_checks++; if (at_a !== m_hold) begin n_fail++; $display("FAIL rnd_at_target cyc %0d got %b want %b", cyc, at_a, m_hold); end
            n_checks++; if (busy_a !== (!m_idle && !m_hold)) begin n_fail++; $display("FAIL rnd_busy cyc %0d got %b want %b", cyc, busy_a, !m_idle && !m_hold); end
            n_checks++; if (pe_a !== (tb_cnt == 10'h3FF)) begin n_fail++; $display("FAIL rnd_period_end cyc %0d got %b want %b", cyc, pe_a, tb_cnt == 10'h3FF); end
            ci.cmd_vld  = ($urandom_range(0, 1499) == 0) || (tb_cnt >= 10'h3FE && $urandom_range(0, 15) == 0);
            ci.cmd_duty = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 120));
            stop_a      = ($urandom_range(0, 5999) == 0) || (cyc == 9000);
            exp_rdy     = !m_stop && !stop_a;
            #1;
            n_checks++; if (ci.cmd_rdy !== exp_rdy) begin n_fail++; $display("FAIL rnd_cmd_rdy cyc %0d got %b want %b", cyc, ci.cmd_rdy, exp_rdy); end
            pe  = (tb_cnt == 10'h3FF);
            acc = ci.cmd_vld && exp_rdy;
            if (pe) begin
                d = (m_target > m_duty) ? m_target - m_duty : m_duty - m_target;
                if (d > 16) d = 16;
                m_duty = (m_target > m_duty) ? m_duty + d : m_duty - d;
                if (m_stop && m_duty == 0) begin
                    m_stop = 0; m_idle = 1;
                end else if (!m_idle && !m_stop && m_duty == m_target) begin
                    m_hold = 1;
                end
            end
            if (stop_a && !m_idle && !m_stop) begin
                m_stop = 1; m_hold = 0; m_target = 0;
            end else if (acc) begin
                c = (int'(ci.cmd_duty) > 1008) ? 1008 : int'(ci.cmd_duty);
                if (m_idle) begin
                    if (c != 0) begin m_idle = 0; m_target = c; end
                end else begin
                    m_target = c;
                    if (c != m_duty) m_hold = 0;
                end
            end
            @(negedge clk);
            if (n_fail > 40) break;
        end
        ci.cmd_vld = 1'b0;
        stop_a = 1'b0;
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        rst_n = 1'b0;
        stop_a = 1'b0; stop_b = 1'b0; fault_a = 1'b0; fault_b = 1'b0;
        ci.cmd_vld = 1'b0; ci.cmd_duty = '0;
        ci2.cmd_vld = 1'b0; ci2.cmd_duty = '0;
        repeat (2) @(negedge clk);
        test_reset();
        test_ramp_up();
        test_stop_vs_cmd();
        test_retarget();
        test_boundary();
        test_reset_mid_ramp();
        test_clamp();
        test_fault();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
